// File: rtl/yp_uart_rx.sv
// UART receiver: start(0), DATA_WIDTH data bits LSB first, optional even parity, stop(1).
// Each bit is sampled once at clk_cnt==HALF; every frame is delivered, qualified by error flags.
module yp_uart_rx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_data,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_rx_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_rx_busy
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  sample_pt;
    logic                  wrap;
    logic [CW-1:0]         clk_cnt_inc;

    assign sample_pt   = (clk_cnt_q == HALF_C);
    assign wrap        = (clk_cnt_q == LAST_C);
    assign clk_cnt_inc = wrap ? '0 : clk_cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        unique case (state_q)
            S_WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (i_rx_data) state_d = S_IDLE;
            end
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!i_rx_data) begin
                    if (CLKS_PER_BIT == 1) begin
                        state_d = S_DATA;
                    end else begin
                        state_d   = S_START;
                        clk_cnt_d = CW'(1);
                    end
                end
            end
            S_START: begin
                clk_cnt_d = clk_cnt_inc;
                if (sample_pt && i_rx_data) begin
                    state_d   = S_IDLE;
                    clk_cnt_d = '0;
                end else if (wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                clk_cnt_d = clk_cnt_inc;
                if (sample_pt) shift_d[bit_cnt_q] = i_rx_data;
                if (wrap) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                clk_cnt_d = clk_cnt_inc;
                if (sample_pt) par_d = i_rx_data ^ (^shift_q);
                if (wrap) state_d = S_STOP;
            end
            S_STOP: begin
                clk_cnt_d = clk_cnt_inc;
                // Leave on the sample cycle so a start bit right after the stop sample is not missed.
                if (sample_pt) begin
                    valid_d   = 1'b1;
                    data_d    = shift_q;
                    perr_d    = (PARITY_EN != 0) ? par_q : 1'b0;
                    ferr_d    = ~i_rx_data;
                    clk_cnt_d = '0;
                    state_d   = i_rx_data ? S_IDLE : S_WAIT_HIGH;
                end
            end
            default: state_d = S_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_WAIT_HIGH;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_data_out   = data_q;
    assign o_rx_valid   = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_rx_busy    = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);

endmodule

// File: tb/tb_yp_uart_rx.sv
// Bench for yp_uart_rx: per-cycle line waveforms decoded by a frame-level model (bit k sampled
// at S + k*CPB + CPB/2) and compared every cycle against a CPB=1 and a CPB=16 instance.
module tb_yp_uart_rx;
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx1  = 1'b1;
    logic       rx16 = 1'b1;
    logic [7:0] d1_data, d16_data;
    logic       d1_valid, d1_perr, d1_ferr, d1_busy;
    logic       d16_valid, d16_perr, d16_ferr, d16_busy;

    always #5 clk = ~clk;

    yp_uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut_cpb1 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx1),
        .o_data_out(d1_data), .o_rx_valid(d1_valid), .o_parity_err(d1_perr),
        .o_frame_err(d1_ferr), .o_rx_busy(d1_busy)
    );

    yp_uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(1)) u_dut_cpb16 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx16),
        .o_data_out(d16_data), .o_rx_valid(d16_valid), .o_parity_err(d16_perr),
        .o_frame_err(d16_ferr), .o_rx_busy(d16_busy)
    );

    int checks   = 0;
    int failures = 0;

    bit         wave[$];
    bit         exp_valid[];
    bit         exp_busy[];
    bit         exp_perr[];
    bit         exp_ferr[];
    logic [7:0] exp_data[];

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_bits(input bit b, input int n);
        repeat (n) wave.push_back(b);
    endtask

    task automatic push_frame(input logic [7:0] d, input int cpb, input bit bad_par,
                              input bit stop);
        push_bits(1'b0, cpb);
        for (int i = 0; i < 8; i++) push_bits(d[i], cpb);
        push_bits((^d) ^ bad_par, cpb);
        push_bits(stop, cpb);
    endtask

    task automatic mark_busy(input int a, input int b, input int n);
        for (int k = a; k <= b && k < n; k++) exp_busy[k] = 1'b1;
    endtask

    // Frame-level decode of the whole waveform, starting from the post-reset wait-for-high.
    task automatic build_expect(input int cpb);
        int         n, t, s, ts, half;
        bit         wait_hi, p, st, cur_p, cur_f;
        logic [7:0] d, cur_d;
        n    = wave.size();
        half = cpb / 2;
        exp_valid = new[n];
        exp_busy  = new[n];
        exp_perr  = new[n];
        exp_ferr  = new[n];
        exp_data  = new[n];
        for (int i = 0; i < n; i++) begin
            exp_valid[i] = 0; exp_busy[i] = 0; exp_perr[i] = 0; exp_ferr[i] = 0;
            exp_data[i] = 8'h00;
        end
        t = 0;
        wait_hi = 1'b1;
        while (t < n) begin
            if (wait_hi) begin
                if (wave[t]) wait_hi = 1'b0;
                t++;
            end else if (wave[t]) begin
                t++;
            end else begin
                s  = t;
                ts = s + 10 * cpb + half;
                if (s + half < n && wave[s + half]) begin
                    mark_busy(s + 1, s + half, n);
                    t = s + half + 1;
                end else if (ts >= n) begin
                    mark_busy(s + 1, n - 1, n);
                    t = n;
                end else begin
                    for (int i = 0; i < 8; i++) d[i] = wave[s + (i + 1) * cpb + half];
                    p  = wave[s + 9 * cpb + half];
                    st = wave[ts];
                    mark_busy(s + 1, ts, n);
                    if (ts + 1 < n) begin
                        exp_valid[ts + 1] = 1'b1;
                        exp_data[ts + 1]  = d;
                        exp_perr[ts + 1]  = p ^ (^d);
                        exp_ferr[ts + 1]  = ~st;
                    end
                    t       = ts + 1;
                    wait_hi = ~st;
                end
            end
        end
        cur_d = 8'h00; cur_p = 0; cur_f = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_valid[i]) begin
                cur_d = exp_data[i]; cur_p = exp_perr[i]; cur_f = exp_ferr[i];
            end
            exp_data[i] = cur_d; exp_perr[i] = cur_p; exp_ferr[i] = cur_f;
        end
    endtask

    task automatic observe(input int cpb, output logic [7:0] od, output logic ov,
                           output logic op, output logic of, output logic ob);
        if (cpb == 1) begin
            od = d1_data;  ov = d1_valid;  op = d1_perr;  of = d1_ferr;  ob = d1_busy;
        end else begin
            od = d16_data; ov = d16_valid; op = d16_perr; of = d16_ferr; ob = d16_busy;
        end
    endtask

    // Reset, then replay the queued waveform one bit per cycle, checking every output each cycle.
    task automatic run_segment(input int cpb, input string name);
        int         n;
        logic [7:0] od;
        logic       ov, op, of, ob;
        build_expect(cpb);
        n = wave.size();
        @(negedge clk);
        rst = 1'b1; rx1 = 1'b1; rx16 = 1'b1;
        @(negedge clk);
        observe(cpb, od, ov, op, of, ob);
        check({name, ".rst_data"},  -1, 32'(od), 32'h0);
        check({name, ".rst_valid"}, -1, 32'(ov), 32'h0);
        check({name, ".rst_perr"},  -1, 32'(op), 32'h0);
        check({name, ".rst_ferr"},  -1, 32'(of), 32'h0);
        check({name, ".rst_busy"},  -1, 32'(ob), 32'h0);
        rst = 1'b0;
        for (int t = 0; t < n; t++) begin
            observe(cpb, od, ov, op, of, ob);
            check({name, ".valid"}, t, 32'(ov), 32'(exp_valid[t]));
            check({name, ".busy"},  t, 32'(ob), 32'(exp_busy[t]));
            check({name, ".data"},  t, 32'(od), 32'(exp_data[t]));
            check({name, ".perr"},  t, 32'(op), 32'(exp_perr[t]));
            check({name, ".ferr"},  t, 32'(of), 32'(exp_ferr[t]));
            if (cpb == 1) rx1 = wave[t];
            else          rx16 = wave[t];
            @(negedge clk);
        end
        wave.delete();
    endtask

    initial begin
        logic [7:0] c3;
        int         cpb;
        c3 = 8'hC3;

        push_bits(1, 3); push_frame(8'hA5, 1, 0, 1); push_bits(1, 4);
        run_segment(1, "t1_a5");

        push_bits(1, 2); push_frame(8'h00, 1, 0, 1); push_bits(1, 1);
        push_frame(8'hFF, 1, 0, 1); push_bits(1, 3);
        push_frame(8'h96, 1, 0, 1); push_frame(8'h69, 1, 0, 1); push_bits(1, 3);
        run_segment(1, "t2_b2b");

        push_bits(1, 2); push_frame(8'h01, 1, 1, 1); push_bits(1, 3);
        run_segment(1, "t3_par");

        push_bits(1, 2); push_frame(8'h5A, 1, 0, 0); push_bits(0, 5); push_bits(1, 2);
        push_frame(8'h33, 1, 0, 1); push_bits(1, 3);
        run_segment(1, "t4_stop");

        push_bits(1, 20); push_bits(0, 4); push_bits(1, 30);
        push_frame(8'h3C, 16, 0, 1); push_bits(1, 20);
        run_segment(16, "t5_cpb16");

        push_bits(1, 2); push_frame(8'h5D, 1, 0, 1); push_bits(1, 2);
        push_bits(0, 1);
        for (int i = 0; i < 4; i++) push_bits(c3[i], 1);
        run_segment(1, "t6_abort");
        push_bits(1, 2); push_frame(8'h7E, 1, 0, 1); push_bits(1, 3);
        run_segment(1, "t6_after");

        for (int seg = 0; seg < 8; seg++) begin
            cpb = (seg % 2 == 0) ? 1 : 16;
            push_bits(1, 2);
            for (int f = 0; f < 4; f++) begin
                if (cpb == 16 && $urandom_range(0, 2) == 0) begin
                    push_bits(0, int'($urandom_range(1, 7)));
                    push_bits(1, 10);
                end
                if ($urandom_range(0, 4) == 0) begin
                    push_frame(8'($urandom), cpb, ($urandom_range(0, 3) == 0), 1'b0);
                    push_bits(0, int'($urandom_range(0, 5)));
                    push_bits(1, 1);
                end else begin
                    push_frame(8'($urandom), cpb, ($urandom_range(0, 3) == 0), 1'b1);
                end
                push_bits(1, int'($urandom_range(0, 3)) * cpb);
            end
            push_bits(1, 3);
            run_segment(cpb, (cpb == 1) ? "rnd_cpb1" : "rnd_cpb16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
